aes_block_loader: RTL and testbench

Stream-side front/back end for the AES encryption core. Packs 32-bit plaintext words into a 128-bit block, holds the key and derives Nk/Nr from a key-size select, launches the core, waits for its done strobe, captures the 128-bit ciphertext, and serializes it back out as 32-bit words. Sits directly upstream of the encryption core's plaintext/key/Nk/Nr inputs and directly downstream of its ciphertext output.

---
 rtl/aes_block_loader_if.sv | 29 ++
 rtl/aes_block_loader.sv | 146 ++++++++++++++
 tb/tb_aes_block_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_loader_if.sv
// Handshake and core-side signal bundle for aes_block_loader.
// The loader connects through the slave modport; the stream/core environment uses master.
interface aes_block_loader_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] core_pt;
    logic [255:0] core_key;
    logic [3:0]   core_nk;
    logic [3:0]   core_nr;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_ct;

    modport slave (
        input  in_data, in_valid, out_ready, core_done, core_ct,
        output in_ready, out_data, out_valid,
        output core_pt, core_key, core_nk, core_nr, core_start
    );

    modport master (
        output in_data, in_valid, out_ready, core_done, core_ct,
        input  in_ready, out_data, out_valid,
        input  core_pt, core_key, core_nk, core_nr, core_start
    );
endinterface

// File: rtl/aes_block_loader.sv
// AES core front/back end: packs 4 words into a block, launches the core,
// captures the ciphertext and serializes it back out as 4 words.
//
//   state  | meaning
//   FILL   | accept plaintext words into slots 0..3, accept key loads at slot 0
//   LAUNCH | one-cycle core_start pulse
//   WAIT   | wait for core_done or abort on timeout
//   DRAIN  | emit ciphertext words 0..3
module aes_block_loader #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_block_loader_if.slave        bus,
    input  logic [255:0]             key_in_i,
    input  logic [1:0]               key_sel_i,
    input  logic                     key_load_i,
    output logic                     busy_o,
    output logic                     key_err_o,
    output logic                     timeout_err_o
);
    typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [1:0]   word_cnt_q, word_cnt_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic [255:0] key_q, key_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic         key_err_q, key_err_d;
    logic         to_err_q, to_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            word_cnt_q <= '0;
            wait_cnt_q <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            key_q      <= '0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            key_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
            key_q      <= key_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            key_err_q  <= key_err_d;
            to_err_q   <= to_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pt_d       = pt_q;
        ct_d       = ct_q;
        key_d      = key_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        key_err_d  = key_err_q;
        to_err_d   = to_err_q;

        case (state_q)
            FILL: begin
                // Keys only change between blocks so core_key never shifts under a partial block.
                if (key_load_i && word_cnt_q == 2'd0) begin
                    case (key_sel_i)
                        2'd0: begin
                            key_d = {key_in_i[255:128], 128'b0};
                            nk_d  = 4'd4;
                            nr_d  = 4'd10;
                        end
                        2'd1: begin
                            key_d = {key_in_i[255:64], 64'b0};
                            nk_d  = 4'd6;
                            nr_d  = 4'd12;
                        end
                        2'd2: begin
                            key_d = key_in_i;
                            nk_d  = 4'd8;
                            nr_d  = 4'd14;
                        end
                        default: key_err_d = 1'b1;
                    endcase
                end
                if (bus.in_valid) begin
                    pt_d[{~word_cnt_q, 5'b0} +: 32] = bus.in_data;
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    ct_d       = bus.core_ct;
                    word_cnt_d = '0;
                    state_d    = DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    to_err_d   = 1'b1;
                    word_cnt_d = '0;
                    state_d    = FILL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.in_ready   = (state_q == FILL) && !rst;
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_data   = ct_q[{~word_cnt_q, 5'b0} +: 32];
    assign bus.core_start = (state_q == LAUNCH);
    assign bus.core_pt    = pt_q;
    assign bus.core_key   = key_q;
    assign bus.core_nk    = nk_q;
    assign bus.core_nr    = nr_q;
    assign busy_o         = (state_q != FILL);
    assign key_err_o      = key_err_q;
    assign timeout_err_o  = to_err_q;
endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a behavioural AES core and an output scoreboard.
module tb_aes_block_loader;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] K_ALT  = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b0123456789abcdef;
    localparam int CORE_LAT = 11;

    logic clk = 1'b0;
    logic rst;
    logic [255:0] key_in;
    logic [1:0]   key_sel;
    logic         key_load;
    logic         busy, key_err, timeout_err;

    logic         mdl_done = 1'b0, inj_done = 1'b0;
    logic [127:0] mdl_ct = '0, inj_ct = '0;
    bit           core_en = 1'b1;
    int           n_start = 0;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0]  exp_q[$];
    logic [255:0] exp_key;

    aes_block_loader_if bus ();

    assign bus.core_done = mdl_done | inj_done;
    assign bus.core_ct   = inj_done ? inj_ct : mdl_ct;

    aes_block_loader #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .key_in_i(key_in), .key_sel_i(key_sel), .key_load_i(key_load),
        .busy_o(busy), .key_err_o(key_err), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference core: FIPS-197 C.1 vector, otherwise an arbitrary keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [255:0] key);
        if (pt == C1_PT && key == {C1_KEY, 128'b0}) return C1_CT;
        return {pt[94:0], pt[127:95]} ^ key[255:128] ^ key[127:0] ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    initial begin
        logic [127:0] cpt;
        logic [255:0] ckey;
        forever begin
            @(negedge clk);
            if (!rst && bus.core_start) begin
                n_start++;
                if (core_en) begin
                    cpt  = bus.core_pt;
                    ckey = bus.core_key;
                    repeat (CORE_LAT) @(posedge clk);
                    #1 mdl_done = 1'b1;
                    mdl_ct = core_fn(cpt, ckey);
                    @(posedge clk);
                    #1 mdl_done = 1'b0;
                end
            end
        end
    end

    // Output scoreboard plus hold-under-backpressure check.
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("out_hold_valid", bus.out_valid, 1);
                chk("out_hold_data", bus.out_data, held_d);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_word", bus.out_data, exp_q.pop_front());
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] k, input logic [1:0] sel);
        key_in   = k;
        key_sel  = sel;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic send_words(input logic [127:0] pt, input bit rnd, input bit push,
                              input bit klo, input logic [255:0] kin, input logic [1:0] ksel);
        logic [127:0] ct;
        bit ok;
        if (push) begin
            ct = core_fn(pt, exp_key);
            for (int i = 0; i < 4; i++) exp_q.push_back(ct[127 - 32*i -: 32]);
        end
        for (int w = 0; w < 4; w++) begin
            if (rnd) repeat ($urandom_range(0, 2)) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = pt[127 - 32*w -: 32];
            if (klo && w == 0) begin
                key_in   = kin;
                key_sel  = ksel;
                key_load = 1'b1;
            end
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                ok = bus.in_ready;
                tick();
            end
            chk("in_handshake", ok, 1);
            bus.in_valid = 1'b0;
            key_load     = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        key_in = '0; key_sel = '0; key_load = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

        // Reset
        tick();
        @(negedge clk);
        chk("rst_in_ready_low", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_core_pt", bus.core_pt, 0);
        chk("rst_core_key", bus.core_key, 0);
        chk("rst_nk", bus.core_nk, 4);
        chk("rst_nr", bus.core_nr, 10);
        chk("rst_start", bus.core_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_errs", {key_err, timeout_err}, 0);
        tick();

        // FIPS-197 C.1, junk in the unused key half must be zeroed
        load_key({C1_KEY, 128'hdeadbeef_cafef00d_01234567_89abcdef}, 2'd0);
        exp_key = {C1_KEY, 128'b0};
        @(negedge clk);
        chk("c1_key", bus.core_key, exp_key);
        chk("c1_nk", bus.core_nk, 4);
        chk("c1_nr", bus.core_nr, 10);
        tick();
        n_start = 0;
        send_words(C1_PT, 0, 1, 0, '0, '0);
        wait_drain("c1_drain", 100);
        chk("c1_one_start", n_start, 1);

        // Key size selects
        load_key(K256, 2'd1);
        exp_key = {K256[255:64], 64'b0};
        @(negedge clk);
        chk("k192_key", bus.core_key, exp_key);
        chk("k192_low_zero", bus.core_key[63:0], 0);
        chk("k192_nknr", {bus.core_nk, bus.core_nr}, {4'd6, 4'd12});
        tick();
        load_key(K256, 2'd2);
        exp_key = K256;
        @(negedge clk);
        chk("k256_key", bus.core_key, exp_key);
        chk("k256_nknr", {bus.core_nk, bus.core_nr}, {4'd8, 4'd14});
        tick();
        load_key(K_ALT, 2'd3);
        @(negedge clk);
        chk("kbad_err", key_err, 1);
        chk("kbad_key_kept", bus.core_key, exp_key);
        chk("kbad_nknr_kept", {bus.core_nk, bus.core_nr}, {4'd8, 4'd14});
        tick();

        // Key load together with the first word; then a key load during WAIT is ignored
        exp_key = {K_ALT[255:128], 128'b0};
        send_words(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 0, 1, 1, K_ALT, 2'd0);
        @(negedge clk);
        chk("kfirst_key", bus.core_key, exp_key);
        chk("kfirst_start", bus.core_start, 1);
        tick();
        load_key(K256, 2'd2);
        @(negedge clk);
        chk("kwait_busy", busy, 1);
        chk("kwait_key_kept", bus.core_key, exp_key);
        chk("kwait_nk_kept", bus.core_nk, 4);
        tick();
        wait_drain("kfirst_drain", 100);

        // Backpressure on both sides over 3 blocks
        load_key(K256, 2'd2);
        exp_key = K256;
        fork
            begin
                for (int b = 0; b < 3; b++)
                    send_words({$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, '0, '0);
            end
            begin
                repeat (300) begin
                    tick();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain", 300);

        // Timeout: core never answers
        core_en = 1'b0;
        send_words(128'h11111111_22222222_33333333_44444444, 0, 0, 0, '0, '0);
        @(negedge clk);
        chk("to_launch", bus.core_start, 1);
        repeat (16) @(negedge clk);
        chk("to_not_yet", timeout_err, 0);
        chk("to_busy_in_wait", busy, 1);
        @(negedge clk);
        chk("to_err", timeout_err, 1);
        chk("to_fill", {busy, bus.in_ready}, 2'b01);
        chk("to_no_out", bus.out_valid, 0);
        tick();
        core_en = 1'b1;
        send_words(128'h55555555_66666666_77777777_88888888, 0, 1, 0, '0, '0);
        wait_drain("to_next_drain", 100);

        // core_done while in FILL
        inj_ct = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        @(negedge clk);
        chk("stray_done_no_out", bus.out_valid, 0);
        chk("stray_done_idle", busy, 0);
        tick();

        // Reset in the middle of DRAIN after two words
        bus.out_ready = 1'b0;
        send_words(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc, 0, 1, 0, '0, '0);
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            got = bus.out_valid;
            tick();
        end
        chk("rd_reached_drain", got, 1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        chk("rd_two_consumed", exp_q.size(), 2);
        exp_q.delete();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rd_out_valid", bus.out_valid, 0);
        chk("rd_busy", busy, 0);
        chk("rd_in_ready", bus.in_ready, 1);
        chk("rd_key_cleared", bus.core_key, 0);
        chk("rd_errs_cleared", {key_err, timeout_err}, 0);
        tick();
        load_key({C1_KEY, 128'b0}, 2'd0);
        exp_key = {C1_KEY, 128'b0};
        send_words(C1_PT, 0, 1, 0, '0, '0);
        wait_drain("rd_fresh_drain", 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
